avalon_burst_arbiter: RTL and testbench

- N-master to 1-slave Avalon-MM interconnect with a built-in round-robin arbiter.
- Successor to the externally steered AvalonMux: it selects internally and holds the grant for a whole burst.
- Adds read-data-valid routing so pipelined burst reads return to the correct master.
- Sits between CPU/DMA masters and a shared memory or peripheral slave.

---
 rtl/avalon_pkg.sv | 15 +
 rtl/rr_priority_select.sv | 32 +++
 rtl/avalon_burst_arbiter.sv | 153 +++++++++++++++
 tb/tb_avalon_burst_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pkg.sv
// Shared types for the burst arbiter: FSM state encoding and the grant-index width helper.
package avalon_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_WR = 2'd1,
        GRANT_RD = 2'd2,
        RD_DATA  = 2'd3
    } state_t;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin pick: first requester at or above the pointer, wrapping modulo NUM_MASTERS.
module rr_priority_select
    import avalon_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int GW          = grant_w(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [GW-1:0]          ptr,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [GW-1:0]          grant_idx,
    output logic                   any_req
);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && req[(int'(ptr) + k) % NUM_MASTERS]) begin
                found                                = 1'b1;
                grant[(int'(ptr) + k) % NUM_MASTERS] = 1'b1;
                grant_idx                            = GW'((int'(ptr) + k) % NUM_MASTERS);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/avalon_burst_arbiter.sv
// N-to-1 Avalon-MM interconnect: round-robin grant held for a whole burst, single outstanding read.
//   state    | meaning
//   IDLE     | no owner; arbitrate among requesters
//   GRANT_WR | owner's write burst forwarded until last beat accepted
//   GRANT_RD | owner's read command forwarded until slave accepts it
//   RD_DATA  | returning read beats to the owner only
module avalon_burst_arbiter
    import avalon_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int BURST_W     = 8
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   i_AVIn_Addr,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] i_AVIn_ByteEn,
    input  logic [NUM_MASTERS-1:0]          i_AVIn_Read,
    input  logic [NUM_MASTERS-1:0]          i_AVIn_Write,
    input  logic [NUM_MASTERS*DATA_W-1:0]   i_AVIn_WriteData,
    input  logic [NUM_MASTERS*BURST_W-1:0]  i_AVIn_BurstCount,
    output logic [NUM_MASTERS*DATA_W-1:0]   o_AVIn_ReadData,
    output logic [NUM_MASTERS-1:0]          o_AVIn_ReadDataValid,
    output logic [NUM_MASTERS-1:0]          o_AVIn_WaitRequest,
    output logic [ADDR_W-1:0]               o_AVOut_Addr,
    output logic [DATA_W/8-1:0]             o_AVOut_ByteEn,
    output logic                            o_AVOut_Read,
    output logic                            o_AVOut_Write,
    output logic [DATA_W-1:0]               o_AVOut_WriteData,
    output logic [BURST_W-1:0]              o_AVOut_BurstCount,
    input  logic [DATA_W-1:0]               i_AVOut_ReadData,
    input  logic                            i_AVOut_ReadDataValid,
    input  logic                            i_AVOut_WaitRequest
);

    localparam int GW   = grant_w(NUM_MASTERS);
    localparam int BE_W = DATA_W / 8;
    localparam int CW   = BURST_W + 1;

    state_t                 state, state_nxt;
    logic [GW-1:0]          gnt_idx, gnt_idx_nxt, ptr, ptr_nxt, sel_idx;
    logic [NUM_MASTERS-1:0] gnt_oh, gnt_oh_nxt, sel_oh, req;
    logic [CW-1:0]          beat_cnt, beat_cnt_nxt, burst_len, burst_len_nxt;
    logic [CW-1:0]          eff_len, cur_len;
    logic [BURST_W-1:0]     g_bc;
    logic                   g_rd, g_wr, any_req;

    assign req = i_AVIn_Read | i_AVIn_Write;

    rr_priority_select #(.NUM_MASTERS(NUM_MASTERS), .GW(GW)) u_rr (
        .req       (req),
        .ptr       (ptr),
        .grant     (sel_oh),
        .grant_idx (sel_idx),
        .any_req   (any_req)
    );

    assign g_rd               = i_AVIn_Read[gnt_idx];
    assign g_wr               = i_AVIn_Write[gnt_idx];
    assign g_bc               = i_AVIn_BurstCount[int'(gnt_idx)*BURST_W +: BURST_W];
    assign o_AVOut_Addr       = i_AVIn_Addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign o_AVOut_ByteEn     = i_AVIn_ByteEn[int'(gnt_idx)*BE_W +: BE_W];
    assign o_AVOut_WriteData  = i_AVIn_WriteData[int'(gnt_idx)*DATA_W +: DATA_W];
    assign o_AVOut_BurstCount = g_bc;
    assign o_AVIn_ReadData    = {NUM_MASTERS{i_AVOut_ReadData}};

    // A zero burst count means one beat; the live count is used only until the first beat latches it.
    assign eff_len = (g_bc == '0) ? CW'(1) : {1'b0, g_bc};
    assign cur_len = (beat_cnt == '0) ? eff_len : burst_len;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= IDLE;
            gnt_idx   <= '0;
            gnt_oh    <= '0;
            ptr       <= '0;
            beat_cnt  <= '0;
            burst_len <= '0;
        end else begin
            state     <= state_nxt;
            gnt_idx   <= gnt_idx_nxt;
            gnt_oh    <= gnt_oh_nxt;
            ptr       <= ptr_nxt;
            beat_cnt  <= beat_cnt_nxt;
            burst_len <= burst_len_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        gnt_idx_nxt          = gnt_idx;
        gnt_oh_nxt           = gnt_oh;
        ptr_nxt              = ptr;
        beat_cnt_nxt         = beat_cnt;
        burst_len_nxt        = burst_len;
        o_AVOut_Read         = 1'b0;
        o_AVOut_Write        = 1'b0;
        o_AVIn_WaitRequest   = '1;
        o_AVIn_ReadDataValid = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_idx_nxt  = sel_idx;
                    gnt_oh_nxt   = sel_oh;
                    ptr_nxt      = (sel_idx == GW'(NUM_MASTERS - 1)) ? '0 : sel_idx + 1'b1;
                    beat_cnt_nxt = '0;
                    state_nxt    = i_AVIn_Write[sel_idx] ? GRANT_WR : GRANT_RD;
                end
            end
            GRANT_WR: begin
                o_AVOut_Write      = g_wr;
                o_AVIn_WaitRequest = ~gnt_oh | {NUM_MASTERS{i_AVOut_WaitRequest}};
                if (g_wr && !i_AVOut_WaitRequest) begin
                    if (beat_cnt == '0)
                        burst_len_nxt = eff_len;
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    if (beat_cnt + 1'b1 == cur_len) begin
                        state_nxt  = IDLE;
                        gnt_oh_nxt = '0;
                    end
                end else if (beat_cnt == '0 && !g_wr && !g_rd) begin
                    state_nxt  = IDLE;
                    gnt_oh_nxt = '0;
                end
            end
            GRANT_RD: begin
                o_AVOut_Read       = g_rd;
                o_AVIn_WaitRequest = ~gnt_oh | {NUM_MASTERS{i_AVOut_WaitRequest}};
                if (g_rd && !i_AVOut_WaitRequest) begin
                    burst_len_nxt = eff_len;
                    beat_cnt_nxt  = '0;
                    state_nxt     = RD_DATA;
                end else if (!g_rd && !g_wr) begin
                    state_nxt  = IDLE;
                    gnt_oh_nxt = '0;
                end
            end
            RD_DATA: begin
                o_AVIn_ReadDataValid = gnt_oh & {NUM_MASTERS{i_AVOut_ReadDataValid}};
                if (i_AVOut_ReadDataValid) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    if (beat_cnt + 1'b1 == burst_len) begin
                        state_nxt  = IDLE;
                        gnt_oh_nxt = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// Bench for avalon_burst_arbiter: transaction-level round-robin model plus a randomized slave.
module tb_avalon_burst_arbiter;

    localparam int NM  = 4;
    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int BW  = 8;
    localparam int BEW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NM*AW-1:0]  av_addr;
    logic [NM*BEW-1:0] av_be;
    logic [NM-1:0]     av_rd, av_wr;
    logic [NM*DW-1:0]  av_wd;
    logic [NM*BW-1:0]  av_bc;
    logic [NM*DW-1:0]  av_rdata;
    logic [NM-1:0]     av_rdv, av_wait;
    logic [AW-1:0]     s_addr;
    logic [BEW-1:0]    s_be;
    logic              s_read, s_write;
    logic [DW-1:0]     s_wd;
    logic [BW-1:0]     s_bc;
    logic [DW-1:0]     s_rdata;
    logic              s_rdv, s_wait;

    logic [AW-1:0]  m_addr[NM];
    logic [BEW-1:0] m_be[NM];
    logic           m_rd[NM], m_wr[NM];
    logic [DW-1:0]  m_wd[NM];
    logic [BW-1:0]  m_bc[NM];

    always_comb begin
        av_addr = '0; av_be = '0; av_rd = '0; av_wr = '0; av_wd = '0; av_bc = '0;
        for (int j = 0; j < NM; j++) begin
            av_addr[j*AW +: AW]   = m_addr[j];
            av_be[j*BEW +: BEW]   = m_be[j];
            av_rd[j]              = m_rd[j];
            av_wr[j]              = m_wr[j];
            av_wd[j*DW +: DW]     = m_wd[j];
            av_bc[j*BW +: BW]     = m_bc[j];
        end
    end

    avalon_burst_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
        .i_Clk                 (clk),
        .i_Rst_n               (rst_n),
        .i_AVIn_Addr           (av_addr),
        .i_AVIn_ByteEn         (av_be),
        .i_AVIn_Read           (av_rd),
        .i_AVIn_Write          (av_wr),
        .i_AVIn_WriteData      (av_wd),
        .i_AVIn_BurstCount     (av_bc),
        .o_AVIn_ReadData       (av_rdata),
        .o_AVIn_ReadDataValid  (av_rdv),
        .o_AVIn_WaitRequest    (av_wait),
        .o_AVOut_Addr          (s_addr),
        .o_AVOut_ByteEn        (s_be),
        .o_AVOut_Read          (s_read),
        .o_AVOut_Write         (s_write),
        .o_AVOut_WriteData     (s_wd),
        .o_AVOut_BurstCount    (s_bc),
        .i_AVOut_ReadData      (s_rdata),
        .i_AVOut_ReadDataValid (s_rdv),
        .i_AVOut_WaitRequest   (s_wait)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model state
    int            model_ptr = 0;
    int            order[$];
    bit            active[NM], is_wr[NM], cmd_done[NM], new_beat[NM], cfg_both[NM];
    int            beats_left[NM];
    logic [BW-1:0] cfg_bc[NM];
    int            rd_pending = 0;
    int            wait_script[$];
    logic [DW-1:0] rd_script[$];
    int            wait_pct = 30;
    int            rdv_pct  = 70;

    task automatic run_round(input logic [NM-1:0] mask, input logic [NM-1:0] wrm, input string name);
        int  last, cyc, h;
        bit  gap;
        logic [NM-1:0] own;
        order.delete();
        last = model_ptr;
        for (int k = 0; k < NM; k++) begin
            if (mask[(model_ptr + k) % NM]) begin
                order.push_back((model_ptr + k) % NM);
                last = (model_ptr + k) % NM;
            end
        end
        model_ptr = (last + 1) % NM;
        @(negedge clk);
        for (int j = 0; j < NM; j++) begin
            if (mask[j]) begin
                active[j]     = 1'b1;
                is_wr[j]      = wrm[j];
                cmd_done[j]   = 1'b0;
                new_beat[j]   = 1'b0;
                beats_left[j] = (cfg_bc[j] == '0) ? 1 : int'(cfg_bc[j]);
                m_wr[j]       = wrm[j];
                m_rd[j]       = wrm[j] ? cfg_both[j] : 1'b1;
                m_bc[j]       = cfg_bc[j];
            end
        end
        gap = 1'b1;
        cyc = 0;
        while ((order.size() > 0 || gap) && cyc < 400) begin
            if (cyc > 0) begin
                @(negedge clk);
                for (int j = 0; j < NM; j++) begin
                    if (active[j]) begin
                        if (is_wr[j]) begin
                            if (beats_left[j] == 0) begin
                                m_wr[j] = 1'b0; m_rd[j] = 1'b0; active[j] = 1'b0;
                            end else if (new_beat[j]) begin
                                m_wd[j] = $urandom; m_be[j] = BEW'($urandom); new_beat[j] = 1'b0;
                            end
                        end else begin
                            if (cmd_done[j]) m_rd[j] = 1'b0;
                            if (beats_left[j] == 0) active[j] = 1'b0;
                        end
                    end
                end
            end
            if (wait_script.size() > 0) s_wait = (wait_script.pop_front() != 0);
            else                        s_wait = ($urandom_range(0, 99) < wait_pct);
            if (rd_pending > 0 && (rd_script.size() > 0 || $urandom_range(0, 99) < rdv_pct)) begin
                s_rdv   = 1'b1;
                s_rdata = (rd_script.size() > 0) ? rd_script.pop_front() : $urandom;
            end else begin
                s_rdv   = 1'b0;
                s_rdata = $urandom;
            end
            #1;
            if (gap) begin
                n_checks++;
                if ({s_read, s_write} !== 2'b00 || av_wait !== '1 || av_rdv !== '0) begin
                    n_fail++;
                    $display("FAIL %s idle cyc %0d: rd/wr=%b wait=%b rdv=%b, want 00/1111/0000",
                             name, cyc, {s_read, s_write}, av_wait, av_rdv);
                end
                gap = 1'b0;
            end else begin
                h   = order[0];
                own = NM'(1) << h;
                n_checks++;
                if ((av_wait | own) !== '1 || (av_rdv & ~own) !== '0) begin
                    n_fail++;
                    $display("FAIL %s others cyc %0d owner %0d: wait=%b rdv=%b", name, cyc, h, av_wait, av_rdv);
                end
                if (is_wr[h]) begin
                    n_checks++;
                    if ({s_read, s_write} !== 2'b01 || s_addr !== m_addr[h] || s_wd !== m_wd[h] ||
                        s_be !== m_be[h] || s_bc !== m_bc[h] || av_wait[h] !== s_wait) begin
                        n_fail++;
                        $display("FAIL %s wr cyc %0d m%0d: rd/wr=%b addr=%h data=%h bc=%0d wait=%b, want 01 %h %h %0d %b",
                                 name, cyc, h, {s_read, s_write}, s_addr, s_wd, s_bc, av_wait[h],
                                 m_addr[h], m_wd[h], m_bc[h], s_wait);
                    end
                    if (!s_wait) begin
                        beats_left[h]--;
                        new_beat[h] = 1'b1;
                        if (beats_left[h] == 0) begin void'(order.pop_front()); gap = 1'b1; end
                    end
                end else if (!cmd_done[h]) begin
                    n_checks++;
                    if ({s_read, s_write} !== 2'b10 || s_addr !== m_addr[h] || s_bc !== m_bc[h] ||
                        av_wait[h] !== s_wait) begin
                        n_fail++;
                        $display("FAIL %s rdcmd cyc %0d m%0d: rd/wr=%b addr=%h bc=%0d wait=%b, want 10 %h %0d %b",
                                 name, cyc, h, {s_read, s_write}, s_addr, s_bc, av_wait[h], m_addr[h], m_bc[h], s_wait);
                    end
                    if (!s_wait) begin cmd_done[h] = 1'b1; rd_pending = beats_left[h]; end
                end else begin
                    n_checks++;
                    if ({s_read, s_write} !== 2'b00 || av_wait[h] !== 1'b1 || av_rdv[h] !== s_rdv ||
                        av_rdata[h*DW +: DW] !== s_rdata) begin
                        n_fail++;
                        $display("FAIL %s rddata cyc %0d m%0d: rd/wr=%b wait=%b rdv=%b data=%h, want 00 1 %b %h",
                                 name, cyc, h, {s_read, s_write}, av_wait[h], av_rdv[h], av_rdata[h*DW +: DW],
                                 s_rdv, s_rdata);
                    end
                    if (s_rdv) begin
                        beats_left[h]--;
                        rd_pending--;
                        if (beats_left[h] == 0) begin void'(order.pop_front()); gap = 1'b1; end
                    end
                end
            end
            cyc++;
        end
        if (cyc >= 400) begin
            n_fail++;
            $display("FAIL %s timeout: %0d bursts outstanding after %0d cycles, want 0", name, order.size(), cyc);
        end
        s_rdv  = 1'b0;
        s_wait = 1'b0;
        wait_script.delete();
        rd_script.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int j = 0; j < NM; j++) begin
            m_addr[j] = '0; m_be[j] = '0; m_rd[j] = 1'b0; m_wr[j] = 1'b0; m_wd[j] = '0; m_bc[j] = '0;
            active[j] = 1'b0; cfg_both[j] = 1'b0; cfg_bc[j] = '0;
        end
        s_rdata = '0; s_rdv = 1'b0; s_wait = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({s_read, s_write} !== 2'b00 || av_wait !== '1 || av_rdv !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: rd/wr=%b wait=%b rdv=%b, want 00/1111/0000", {s_read, s_write}, av_wait, av_rdv);
        end
    endtask

    task automatic test_single_write();
        m_addr[0] = AW'(3); m_wd[0] = 32'h1; m_be[0] = '1; cfg_bc[0] = 8'd1;
        wait_script = '{0, 1, 0};
        run_round(4'b0001, 4'b0001, "single_wr");
    endtask

    task automatic test_read_burst();
        m_addr[1] = AW'($urandom); cfg_bc[1] = 8'd4;
        wait_script = '{1, 1, 1, 1, 0};
        rd_script   = '{32'hA, 32'hB, 32'hC, 32'hD};
        run_round(4'b0010, 4'b0000, "read_burst");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 2; j++) begin
                m_addr[j] = AW'($urandom); m_wd[j] = $urandom; m_be[j] = '1; cfg_bc[j] = 8'd2;
            end
            run_round(4'b0011, 4'b0011, "back_to_back");
        end
    endtask

    task automatic test_pointer();
        m_addr[1] = AW'($urandom); m_wd[1] = $urandom; m_be[1] = '1; cfg_bc[1] = BW'($urandom_range(1, 3));
        m_addr[3] = AW'($urandom); m_wd[3] = $urandom; m_be[3] = '1; cfg_bc[3] = '0;
        run_round(4'b1010, 4'b1010, "ptr_bc0");
    endtask

    task automatic test_random();
        logic [NM-1:0] mask, wrm;
        for (int r = 0; r < 40; r++) begin
            mask = NM'($urandom_range(1, (1 << NM) - 1));
            wrm  = NM'($urandom);
            for (int j = 0; j < NM; j++) begin
                m_addr[j]   = AW'($urandom);
                m_wd[j]     = $urandom;
                m_be[j]     = BEW'($urandom);
                cfg_bc[j]   = BW'($urandom_range(0, 5));
                cfg_both[j] = ($urandom_range(0, 1) == 1);
            end
            run_round(mask, wrm, "random");
        end
        for (int j = 0; j < NM; j++) cfg_both[j] = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        m_addr[0] = AW'($urandom); m_rd[0] = 1'b1; m_bc[0] = 8'd3; s_wait = 1'b0; s_rdv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_rd[0] = 1'b0; s_rdv = 1'b1; s_rdata = 32'h5A5A_0001;
        #1;
        n_checks++;
        if (av_rdv !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_read_rdv: rdv=%b, want 0001", av_rdv);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s_read, s_write} !== 2'b00 || av_wait !== '1 || av_rdv !== '0) begin
            n_fail++;
            $display("FAIL async_reset: rd/wr=%b wait=%b rdv=%b, want 00/1111/0000", {s_read, s_write}, av_wait, av_rdv);
        end
        @(negedge clk);
        s_rdv = 1'b0;
        rst_n = 1'b1;
        model_ptr  = 0;
        rd_pending = 0;
        for (int j = 0; j < NM; j++) begin
            m_addr[j] = AW'($urandom); m_wd[j] = $urandom; m_be[j] = '1; cfg_bc[j] = 8'd1;
        end
        run_round(4'b1111, 4'b1111, "after_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_read_burst();
        test_back_to_back();
        test_pointer();
        test_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
